// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequence transmitter.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [7:0]  MAXAUX          = 8'hFF;
    localparam int unsigned SEG_LIMIT       = 256;
    localparam int          PAYLOAD_LEN_DEF = 64;
    localparam int          IFG_LEN_DEF     = 12;

    // Byte index covers the largest legal payload (1500); gap counter covers IFG_LEN.
    localparam int          IDX_W           = 11;
    localparam int          GAP_W           = 16;

    // A round needs at least one segment, and the receiver cannot track more than SEG_LIMIT.
    function automatic logic [8:0] clamp_seg_max(input logic [15:0] n);
        if (n == 16'd0) begin
            return 9'd1;
        end
        if (n > 16'(SEG_LIMIT)) begin
            return 9'(SEG_LIMIT);
        end
        return n[8:0];
    endfunction

endpackage

// File: rtl/frame_seq_byte_mux.sv
// Payload byte selection: aux and seg bytes at fixed offsets, index bytes elsewhere.
module frame_seq_byte_mux
    import frame_seq_pkg::*;
#(
    parameter int WHEREIS_AUX = 0
) (
    input  logic [IDX_W-1:0] byte_idx,
    input  logic [7:0]       aux,
    input  logic [15:0]      seg,
    output logic [7:0]       byte_out
);

    localparam logic [IDX_W-1:0] AUX_POS  = IDX_W'(WHEREIS_AUX);
    localparam logic [IDX_W-1:0] SEGL_POS = IDX_W'(WHEREIS_AUX + 1);
    localparam logic [IDX_W-1:0] SEGH_POS = IDX_W'(WHEREIS_AUX + 2);

    always_comb begin
        byte_out = byte_idx[7:0];
        if (byte_idx == AUX_POS) begin
            byte_out = aux;
        end else if (byte_idx == SEGL_POS) begin
            byte_out = seg[7:0];
        end else if (byte_idx == SEGH_POS) begin
            byte_out = seg[15:8];
        end
    end

endmodule

// File: rtl/frame_seq_tx.sv
// Sequenced frame transmitter: numbered frames (aux round, seg segment) separated by idle gaps.
// Optional macro FRAME_SEQ_TX_DROP_INJECT_EN adds drop_period to skip every Nth frame slot.
module frame_seq_tx
    import frame_seq_pkg::*;
#(
    parameter int WHEREIS_AUX = 0,
    parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEF,
    parameter int IFG_LEN     = IFG_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] segment_number_max,
`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
    input  logic [7:0]  drop_period,
`endif
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic [15:0] seg,
    output logic [7:0]  aux,
    output logic [31:0] frames_sent,
    output logic        busy,
    output logic [1:0]  state
);

    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(PAYLOAD_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_LEN - 1);

    state_t           state_r;
    logic [1:0]       rst_sync;
    logic             rst_n_int;
    logic [8:0]       seg_max_r;
    logic [IDX_W-1:0] byte_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             skip_r;
    logic             slot_drop;
    logic [IDX_W-1:0] mux_idx;
    logic [7:0]       mux_aux;
    logic [15:0]      mux_seg;
    logic [7:0]       mux_byte;
    logic [7:0]       seg_last;
    logic             seg_wrap;

    // Assertion is immediate; release reaches the logic only after two clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // The mux looks one byte ahead; on start the cleared seg/aux are presented before they load.
    always_comb begin
        mux_idx  = (state_r == ST_SEND) ? byte_idx + IDX_W'(1) : '0;
        mux_aux  = (state_r == ST_IDLE) ? '0 : aux;
        mux_seg  = (state_r == ST_IDLE) ? '0 : seg;
        seg_last = 8'(seg_max_r - 9'd1);
        seg_wrap = (seg == {8'h00, seg_last});
    end

    frame_seq_byte_mux #(
        .WHEREIS_AUX (WHEREIS_AUX)
    ) u_byte_mux (
        .byte_idx (mux_idx),
        .aux      (mux_aux),
        .seg      (mux_seg),
        .byte_out (mux_byte)
    );

`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
    logic [7:0] slot_cnt;
    logic       frame_begin;

    // slot_cnt counts slots started modulo drop_period; the slot that reaches drop_period is dropped.
    always_comb begin
        frame_begin = ((state_r == ST_IDLE) && start && !stop) ||
                      ((state_r == ST_GAP) && !stop && (gap_cnt == GAP_LAST));
        slot_drop   = (drop_period != 8'd0) &&
                      (({1'b0, slot_cnt} + 9'd1) == {1'b0, drop_period});
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            slot_cnt <= '0;
        end else if (state_r == ST_HALT) begin
            slot_cnt <= '0;
        end else if (frame_begin) begin
            slot_cnt <= slot_drop ? 8'd0 : slot_cnt + 8'd1;
        end
    end
`else
    assign slot_drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_r     <= ST_IDLE;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            seg         <= '0;
            aux         <= '0;
            frames_sent <= '0;
            seg_max_r   <= 9'd1;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            skip_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_r   <= ST_SEND;
                        seg       <= '0;
                        aux       <= '0;
                        seg_max_r <= clamp_seg_max(segment_number_max);
                        byte_idx  <= '0;
                        tx_en     <= !slot_drop;
                        skip_r    <= slot_drop;
                        tx_data   <= mux_byte;
                    end
                end
                ST_SEND: begin
                    if (byte_idx == BYTE_LAST) begin
                        tx_en <= 1'b0;
                        if (!skip_r) begin
                            frames_sent <= frames_sent + 32'd1;
                        end
                        if (stop) begin
                            state_r <= ST_HALT;
                        end else begin
                            // Numbering advances as the gap begins so the next frame sees it from byte 0.
                            state_r <= ST_GAP;
                            gap_cnt <= '0;
                            if (seg_wrap) begin
                                seg <= '0;
                                aux <= (aux == MAXAUX) ? 8'd0 : aux + 8'd1;
                            end else begin
                                seg <= seg + 16'd1;
                            end
                        end
                    end else begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        tx_data  <= mux_byte;
                        tx_en    <= !skip_r;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state_r <= ST_HALT;
                    end else if (gap_cnt == GAP_LAST) begin
                        state_r  <= ST_SEND;
                        byte_idx <= '0;
                        tx_en    <= !slot_drop;
                        skip_r   <= slot_drop;
                        tx_data  <= mux_byte;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_HALT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state_r != ST_IDLE);
    assign state = state_r;

endmodule

// File: tb/tb_frame_seq_tx.sv
// Self-checking bench for frame_seq_tx: default instance plus a short-frame instance.
module tb_frame_seq_tx;

    localparam int A_LEN = 64;
    localparam int A_IFG = 12;
    localparam int B_LEN = 6;
    localparam int B_AUX = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic [15:0] smax_a = '0, smax_b = '0;
`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
    logic [7:0]  drop_a = '0, drop_b = '0;
`endif

    logic        a_tx_en, b_tx_en, a_busy, b_busy;
    logic [7:0]  a_tx_data, b_tx_data, a_aux, b_aux;
    logic [15:0] a_seg, b_seg;
    logic [31:0] a_fs, b_fs;
    logic [1:0]  a_state, b_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  fq[$];
    logic [15:0] f_seg;
    logic [7:0]  f_aux;
    logic [31:0] f_fs;
    logic        f_got, f_steady;

    typedef struct {
        int smax;
        int nframes;
        int exp_seg;
        int exp_aux;
    } vec_t;
    vec_t tbl[10];

    frame_seq_tx dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start_a),
        .stop               (stop_a),
        .segment_number_max (smax_a),
`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
        .drop_period        (drop_a),
`endif
        .tx_en              (a_tx_en),
        .tx_data            (a_tx_data),
        .seg                (a_seg),
        .aux                (a_aux),
        .frames_sent        (a_fs),
        .busy               (a_busy),
        .state              (a_state)
    );

    frame_seq_tx #(
        .WHEREIS_AUX (B_AUX),
        .PAYLOAD_LEN (B_LEN),
        .IFG_LEN     (1)
    ) dut_s (
        .clk                (clk),
        .rst                (rst),
        .start              (start_b),
        .stop               (stop_b),
        .segment_number_max (smax_b),
`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
        .drop_period        (drop_b),
`endif
        .tx_en              (b_tx_en),
        .tx_data            (b_tx_data),
        .seg                (b_seg),
        .aux                (b_aux),
        .frames_sent        (b_fs),
        .busy               (b_busy),
        .state              (b_state)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Reference model: frame k after start carries seg = k mod M, aux = (k div M) mod 256.
    function automatic int eff(input int m);
        if (m == 0) return 1;
        if (m > 256) return 256;
        return m;
    endfunction

    function automatic logic [15:0] mseg(input int k, input int m);
        return 16'(k % eff(m));
    endfunction

    function automatic logic [7:0] maux(input int k, input int m);
        return 8'((k / eff(m)) % 256);
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input int wa, input logic [7:0] a,
                                            input logic [15:0] s);
        if (i == wa) return a;
        if (i == wa + 1) return s[7:0];
        if (i == wa + 2) return s[15:8];
        return 8'(i);
    endfunction

    function automatic logic en_of(input bit w);
        return w ? b_tx_en : a_tx_en;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_a = 0; stop_a = 0; start_b = 0; stop_b = 0;
        rst = 0;
        tick(2);
        rst = 1;
        tick(3);
    endtask

    task automatic pulse_start(input bit w, input logic [15:0] m);
        if (w) begin smax_b = m; start_b = 1; end
        else begin smax_a = m; start_a = 1; end
        @(negedge clk);
        start_a = 0;
        start_b = 0;
    endtask

    // Waits (bounded) for tx_en, then collects the bytes of one frame.
    task automatic grab(input bit w, input int budget);
        int waited = 0;
        fq.delete();
        f_got = 0;
        f_steady = 1;
        while (!en_of(w) && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!en_of(w)) return;
        f_got = 1;
        f_seg = w ? b_seg : a_seg;
        f_aux = w ? b_aux : a_aux;
        f_fs  = w ? b_fs : a_fs;
        while (en_of(w) && fq.size() < 2000) begin
            fq.push_back(w ? b_tx_data : a_tx_data);
            if ((w ? b_seg : a_seg) !== f_seg || (w ? b_aux : a_aux) !== f_aux) f_steady = 0;
            @(negedge clk);
        end
    endtask

    task automatic count_gap(input bit w, input int budget, output int g);
        g = 0;
        while (!en_of(w) && g < budget) begin
            g++;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input bit w, input int k, input int m, input string tag);
        int plen = w ? B_LEN : A_LEN;
        int wa   = w ? B_AUX : 0;
        int bad  = 0;
        logic [15:0] es = mseg(k, m);
        logic [7:0]  ea = maux(k, m);
        check({tag, "_present"}, 64'(f_got), 64'd1);
        check({tag, "_len"}, 64'(fq.size()), 64'(plen));
        foreach (fq[i]) if (fq[i] !== exp_byte(i, wa, ea, es)) bad++;
        check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
        check({tag, "_seg"}, 64'(f_seg), 64'(es));
        check({tag, "_aux"}, 64'(f_aux), 64'(ea));
        check({tag, "_steady"}, 64'(f_steady), 64'd1);
    endtask

    initial begin
        int cnt, g, w, n, m, mode, exp_fs;
        logic [7:0] b3;

        tbl[0] = '{4,     1,    0,   0};
        tbl[1] = '{4,     1025, 0,   0};
        tbl[2] = '{0,     5,    0,   4};
        tbl[3] = '{1,     3,    0,   2};
        tbl[4] = '{1000,  257,  0,   1};
        tbl[5] = '{1000,  256,  255, 0};
        tbl[6] = '{256,   300,  43,  1};
        tbl[7] = '{257,   260,  3,   1};
        tbl[8] = '{3,     7,    0,   2};
        tbl[9] = '{65535, 2,    1,   0};

        // Reset state
        #1 rst = 0;
        tick(3);
        check("rst_tx_en", 64'(a_tx_en), 64'd0);
        check("rst_tx_data", 64'(a_tx_data), 64'd0);
        check("rst_seg", 64'(a_seg), 64'd0);
        check("rst_aux", 64'(a_aux), 64'd0);
        check("rst_frames_sent", 64'(a_fs), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_state", 64'(a_state), 64'd0);
        rst = 1;
        @(negedge clk);
        check("release_state_idle", 64'(a_state), 64'd0);
        tick(3);

        // First frame layout, latency and inter-frame gap
        pulse_start(0, 16'd4);
        check("first_byte_latency", 64'(a_tx_en), 64'd1);
        grab(0, 100);
        check_frame(0, 0, 4, "f1");
        b3 = (fq.size() > 3) ? fq[3] : 8'hEE;
        check("f1_byte3", 64'(b3), 64'h03);
        check("f1_frames_sent", 64'(a_fs), 64'd1);
        check("gap_busy", 64'(a_busy), 64'd1);
        count_gap(0, 100, g);
        check("ifg_len", 64'(g), 64'(A_IFG));
        grab(0, 100);
        check_frame(0, 1, 4, "f2");
        check("f2_frames_sent", 64'(a_fs), 64'd2);
        stop_a = 1;
        tick(3);
        stop_a = 0;
        check("stopped_idle", 64'(a_state), 64'd0);

        // Stop mid-SEND at byte 10; a start mid-frame is ignored
        do_reset();
        pulse_start(0, 16'd4);
        cnt = a_tx_en ? 1 : 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_a = (i == 5);
            cnt += a_tx_en ? 1 : 0;
        end
        start_a = 0;
        stop_a = 1;
        w = 0;
        while (a_tx_en && w < 200) begin
            @(negedge clk);
            w++;
            if (a_tx_en) cnt++;
        end
        check("stop_mid_frame_len", 64'(cnt), 64'(A_LEN));
        check("stop_halt_state", 64'(a_state), 64'd3);
        check("stop_halt_busy", 64'(a_busy), 64'd1);
        @(negedge clk);
        check("stop_idle_state", 64'(a_state), 64'd0);
        check("stop_idle_busy", 64'(a_busy), 64'd0);
        check("stop_frames_sent", 64'(a_fs), 64'd1);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        check("start_stop_idle_state", 64'(a_state), 64'd0);
        check("start_stop_no_tx", 64'(a_tx_en), 64'd0);
        stop_a = 0;

        // Stop during GAP: no partial frame, numbering already advanced
        pulse_start(0, 16'd4);
        grab(0, 100);
        check_frame(0, 0, 4, "g1");
        tick(2);
        stop_a = 1;
        @(negedge clk);
        check("gap_stop_halt", 64'(a_state), 64'd3);
        @(negedge clk);
        check("gap_stop_idle", 64'(a_state), 64'd0);
        stop_a = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt += a_tx_en ? 1 : 0;
        end
        check("gap_stop_no_tx", 64'(cnt), 64'd0);
        check("gap_stop_frames_sent", 64'(a_fs), 64'd2);
        check("gap_stop_seg_hold", 64'(a_seg), 64'd1);
        check("gap_stop_aux_hold", 64'(a_aux), 64'd0);

        // Reset at byte 20 of frame 3
        do_reset();
        pulse_start(0, 16'd4);
        grab(0, 100);
        grab(0, 100);
        w = 0;
        while (!a_tx_en && w < 100) begin
            @(negedge clk);
            w++;
        end
        tick(20);
        check("f3_byte20", 64'(a_tx_data), 64'd20);
        #2 rst = 0;
        #1;
        check("midrst_tx_en", 64'(a_tx_en), 64'd0);
        check("midrst_frames_sent", 64'(a_fs), 64'd0);
        check("midrst_state", 64'(a_state), 64'd0);
        check("midrst_seg", 64'(a_seg), 64'd0);
        @(negedge clk);
        rst = 1;
        tick(3);
        pulse_start(0, 16'd4);
        grab(0, 100);
        check_frame(0, 0, 4, "post_rst");
        stop_a = 1;
        tick(3);
        stop_a = 0;

        // Table: segment_number_max handling on the short-frame instance
        for (int t = 0; t < 10; t++) begin
            do_reset();
            pulse_start(1, 16'(tbl[t].smax));
            for (int k = 0; k < tbl[t].nframes; k++) begin
                grab(1, 40);
                check_frame(1, k, tbl[t].smax, $sformatf("tbl%0d_k%0d", t, k));
            end
            check($sformatf("tbl%0d_last_seg", t), 64'(f_seg), 64'(tbl[t].exp_seg));
            check($sformatf("tbl%0d_last_aux", t), 64'(f_aux), 64'(tbl[t].exp_aux));
            check($sformatf("tbl%0d_frames_sent", t), 64'(b_fs), 64'(tbl[t].nframes));
            count_gap(1, 20, g);
            check($sformatf("tbl%0d_ifg1", t), 64'(g), 64'd1);
        end

        // Randomised runs with stop in either the gap or the following frame
        for (int it = 0; it < 8; it++) begin
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 12));
            n = $urandom_range(1, 40);
            mode = $urandom_range(0, 1);
            do_reset();
            pulse_start(1, 16'(m));
            for (int k = 0; k < n; k++) begin
                grab(1, 40);
                check_frame(1, k, m, $sformatf("rnd%0d_k%0d", it, k));
            end
            if (mode == 0) begin
                stop_b = 1;
                @(negedge clk);
                exp_fs = n;
            end else begin
                @(negedge clk);
                stop_b = 1;
                grab(1, 10);
                check_frame(1, n, m, $sformatf("rnd%0d_last", it));
                exp_fs = n + 1;
            end
            check($sformatf("rnd%0d_halt", it), 64'(b_state), 64'd3);
            @(negedge clk);
            stop_b = 0;
            check($sformatf("rnd%0d_idle", it), 64'(b_state), 64'd0);
            check($sformatf("rnd%0d_frames_sent", it), 64'(b_fs), 64'(exp_fs));
            check($sformatf("rnd%0d_seg", it), 64'(b_seg), 64'(mseg(n, m)));
            check($sformatf("rnd%0d_aux", it), 64'(b_aux), 64'(maux(n, m)));
        end

`ifdef FRAME_SEQ_TX_DROP_INJECT_EN
        // Every third slot dropped: slots with seg 2, 5 and round-1 seg 0 stay silent
        do_reset();
        drop_b = 8'd3;
        pulse_start(1, 16'd8);
        begin
            int kept[7] = '{0, 1, 3, 4, 6, 7, 9};
            for (int j = 0; j < 7; j++) begin
                grab(1, 40);
                check_frame(1, kept[j], 8, $sformatf("drop_k%0d", kept[j]));
            end
        end
        check("drop_fs_after_9_slots", 64'(f_fs), 64'd6);
        check("drop_fs_after_10_slots", 64'(b_fs), 64'd7);
        drop_b = 8'd0;
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
